// File: rtl/mem_access_pkg.sv
// Purpose: shared types for the M-stage data-memory access unit.
// Holds the memop encodings, data_size codes, FSM state enum and bus widths.
package mips_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } memop_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_if.sv
// Purpose: SRAM-like data bus between the M-stage access unit and memory.
// Ports: req/wr/size/addr/wstrb/wdata from master; addr_ok/data_ok/rdata from slave.
interface mem_access_if;
    import mips_mem_pkg::*;

    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [ADDR_W-1:0]   data_addr;
    logic [STRB_W-1:0]   data_wstrb;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mem_access_align.sv
// Purpose: combinational store alignment, load extraction/extension and
// misalignment detection.
// Ports: memen_i/memop_i/addr_lo_i select the access; wdata_i/rdata_i raw data;
//        size_o, is_store_o, wstrb_o, wdata_o, load_o, adel_o, ades_o results.
module mem_align
    import mips_mem_pkg::*;
(
    input  logic              memen_i,
    input  logic [2:0]        memop_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [1:0]        size_o,
    output logic              is_store_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] load_o,
    output logic              adel_o,
    output logic              ades_o
);

    logic       misalign;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Access size and store replication
    always_comb begin
        size_o  = SIZE_WORD;
        wdata_o = wdata_i;
        case (memop_e'(memop_i))
            OP_LB, OP_LBU, OP_SB: begin
                size_o  = SIZE_BYTE;
                wdata_o = {4{wdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                size_o  = SIZE_HALF;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                size_o  = SIZE_WORD;
                wdata_o = wdata_i;
            end
        endcase
    end

    assign is_store_o = memop_i[2] & (|memop_i[1:0]);
    assign misalign   = ((size_o == SIZE_HALF) && addr_lo_i[0]) ||
                        ((size_o == SIZE_WORD) && (addr_lo_i != 2'b00));
    assign adel_o     = memen_i & ~is_store_o & misalign;
    assign ades_o     = memen_i &  is_store_o & misalign;

    // Byte enables only for a valid store
    always_comb begin
        wstrb_o = '0;
        if (memen_i && is_store_o && !misalign) begin
            case (size_o)
                SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
                SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                default:   wstrb_o = 4'b1111;
            endcase
        end
    end

    // Load lane select and extension
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (memop_e'(memop_i))
            OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o = {24'd0, byte_sel};
            OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o = {16'd0, half_sel};
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Purpose: M-stage data-memory access unit: bus handshake FSM, load capture
// and pipeline stall generation.
// Ports: clk/rst; memenM, memopM, addrM, writedataM, stall_inM from the M stage;
//        readdataM, mem_stallM, adelM, adesM to the pipeline; bus (master) to memory.
module mem_access
    import mips_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              memenM,
    input  logic [2:0]        memopM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              stall_inM,
    output logic [DATA_W-1:0] readdataM,
    output logic              mem_stallM,
    output logic              adelM,
    output logic              adesM,
    mem_access_if.master      bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req;
    logic              err;
    logic              is_store;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_val;

    mem_align u_align (
        .memen_i    (memenM),
        .memop_i    (memopM),
        .addr_lo_i  (addrM[1:0]),
        .wdata_i    (writedataM),
        .rdata_i    (bus.data_rdata),
        .size_o     (size),
        .is_store_o (is_store),
        .wstrb_o    (wstrb),
        .wdata_o    (wdata_rep),
        .load_o     (load_val),
        .adel_o     (adelM),
        .ades_o     (adesM)
    );

    assign err = adelM | adesM;

    // Bus fields follow the M-stage inputs, which hold steady while stalled
    assign bus.data_req   = req;
    assign bus.data_wr    = memenM & is_store;
    assign bus.data_size  = size;
    assign bus.data_addr  = addrM;
    assign bus.data_wstrb = wstrb;
    assign bus.data_wdata = wdata_rep;

    // State and captured load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Handshake FSM; HOLD keeps the load result while downstream is stalled
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        req        = 1'b0;
        mem_stallM = 1'b0;
        readdataM  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (memenM && !err) begin
                    req        = 1'b1;
                    mem_stallM = 1'b1;
                    state_d    = bus.data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                req        = 1'b1;
                mem_stallM = 1'b1;
                if (bus.data_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mem_stallM = ~bus.data_data_ok;
                if (bus.data_data_ok) begin
                    readdataM = load_val;
                    rdata_d   = load_val;
                    state_d   = stall_inM ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!stall_inM) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Purpose: self-checking bench for mem_access; load results go through a
// scoreboard queue filled at issue and drained at data_ok.
module tb_mem_access;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [2:0]  memopM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic        stall_inM;
    logic [31:0] readdataM;
    logic        mem_stallM;
    logic        adelM;
    logic        adesM;

    mem_access_if bus ();

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .memenM     (memenM),
        .memopM     (memopM),
        .addrM      (addrM),
        .writedataM (writedataM),
        .stall_inM  (stall_inM),
        .readdataM  (readdataM),
        .mem_stallM (mem_stallM),
        .adelM      (adelM),
        .adesM      (adesM),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access: aw addr_ok wait cycles, dw data_ok wait cycles, hold stall_inM cycles after data_ok
    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int aw, input int dw, input int hold,
                          input logic [1:0] exp_size, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        logic        is_ld;
        logic [31:0] sb_val;
        is_ld      = (op < 3'd5);
        memenM     = 1'b1;
        memopM     = op;
        addrM      = addr;
        writedataM = wd;
        stall_inM  = 1'b0;
        bus.data_rdata = rd;
        sb_val     = rd;
        if (is_ld) exp_q.push_back(exp_load);
        for (int i = 0; i <= aw; i++) begin
            bus.data_addr_ok = (i == aw);
            @(negedge clk);
            chk("addr_req", 32'(bus.data_req), 32'd1);
            chk("addr_stall", 32'(mem_stallM), 32'd1);
            chk("addr_size", 32'(bus.data_size), 32'(exp_size));
            chk("addr_wstrb", 32'(bus.data_wstrb), 32'(exp_strb));
            chk("addr_wr", 32'(bus.data_wr), 32'(!is_ld));
            chk("addr_addr", bus.data_addr, addr);
            if (!is_ld) chk("addr_wdata", bus.data_wdata, exp_wdata);
            next_cycle();
        end
        bus.data_addr_ok = 1'b0;
        for (int i = 0; i <= dw; i++) begin
            bus.data_data_ok = (i == dw);
            stall_inM = (i == dw) && (hold > 0);
            @(negedge clk);
            chk("data_req", 32'(bus.data_req), 32'd0);
            chk("data_stall", 32'(mem_stallM), 32'(i != dw));
            if (i == dw && is_ld) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    sb_val = exp_q.pop_front();
                    chk("load_data", readdataM, sb_val);
                end
            end
            next_cycle();
        end
        bus.data_data_ok = 1'b0;
        for (int i = 0; i <= hold && hold > 0; i++) begin
            stall_inM = (i < hold);
            @(negedge clk);
            chk("hold_req", 32'(bus.data_req), 32'd0);
            chk("hold_stall", 32'(mem_stallM), 32'd0);
            if (is_ld) chk("hold_data", readdataM, sb_val);
            next_cycle();
        end
        stall_inM = 1'b0;
    endtask

    task automatic idle_cycle(input logic [31:0] exp_rd);
        memenM = 1'b0;
        @(negedge clk);
        chk("idle_req", 32'(bus.data_req), 32'd0);
        chk("idle_stall", 32'(mem_stallM), 32'd0);
        chk("idle_rd", readdataM, exp_rd);
        next_cycle();
    endtask

    // Misaligned access: flags only, no request, no stall
    task automatic misaligned(input logic [2:0] op, input logic [31:0] addr,
                              input logic exp_adel, input logic exp_ades);
        memenM = 1'b1;
        memopM = op;
        addrM  = addr;
        @(negedge clk);
        chk("mis_adel", 32'(adelM), 32'(exp_adel));
        chk("mis_ades", 32'(adesM), 32'(exp_ades));
        chk("mis_req", 32'(bus.data_req), 32'd0);
        chk("mis_stall", 32'(mem_stallM), 32'd0);
        chk("mis_wstrb", 32'(bus.data_wstrb), 32'd0);
        next_cycle();
        memenM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        memenM = 1'b0;
        memopM = 3'd0;
        addrM = 32'h0;
        writedataM = 32'h0;
        stall_inM = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_stall", 32'(mem_stallM), 32'd0);
        chk("rst_rd", readdataM, 32'd0);
        chk("rst_wstrb", 32'(bus.data_wstrb), 32'd0);
        chk("rst_adel", 32'(adelM), 32'd0);
        chk("rst_ades", 32'(adesM), 32'd0);
        next_cycle();

        access(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, SIZE_WORD, 4'b0000, 32'h0, 32'hDEADBEEF);
        idle_cycle(32'hDEADBEEF);
        // Back-to-back loads with no idle cycle between them
        access(OP_LB,  32'h103, 32'h0, 32'h80112233, 0, 0, 0, SIZE_BYTE, 4'b0000, 32'h0, 32'hFFFFFF80);
        access(OP_LBU, 32'h103, 32'h0, 32'h80112233, 0, 0, 0, SIZE_BYTE, 4'b0000, 32'h0, 32'h00000080);
        access(OP_LH,  32'h102, 32'h0, 32'h80112233, 1, 0, 0, SIZE_HALF, 4'b0000, 32'h0, 32'hFFFF8011);
        access(OP_LHU, 32'h100, 32'h0, 32'h80112233, 0, 1, 0, SIZE_HALF, 4'b0000, 32'h0, 32'h00002233);
        access(OP_LB,  32'h101, 32'h0, 32'h80112233, 0, 0, 0, SIZE_BYTE, 4'b0000, 32'h0, 32'h00000022);
        idle_cycle(32'h00000022);
        access(OP_SB,  32'h201, 32'h000000AB, 32'h0, 0, 0, 0, SIZE_BYTE, 4'b0010, 32'hABABABAB, 32'h0);
        access(OP_SH,  32'h202, 32'h00001234, 32'h0, 0, 0, 0, SIZE_HALF, 4'b1100, 32'h12341234, 32'h0);
        access(OP_SH,  32'h200, 32'h00005678, 32'h0, 0, 0, 0, SIZE_HALF, 4'b0011, 32'h56785678, 32'h0);
        access(OP_SW,  32'h204, 32'hCAFEF00D, 32'h0, 2, 0, 0, SIZE_WORD, 4'b1111, 32'hCAFEF00D, 32'h0);
        idle_cycle(32'h0);
        misaligned(OP_LW, 32'h102, 1'b1, 1'b0);
        misaligned(OP_SH, 32'h301, 1'b0, 1'b1);
        misaligned(OP_LH, 32'h103, 1'b1, 1'b0);
        misaligned(OP_SW, 32'h306, 1'b0, 1'b1);
        // Delayed handshake with downstream stall: enters HOLD and keeps the value
        access(OP_LW,  32'h300, 32'h0, 32'h13579BDF, 3, 2, 4, SIZE_WORD, 4'b0000, 32'h0, 32'h13579BDF);
        idle_cycle(32'h13579BDF);

        // Reset while waiting for data_ok
        memenM = 1'b1;
        memopM = OP_LW;
        addrM  = 32'h400;
        bus.data_addr_ok = 1'b1;
        next_cycle();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", 32'(mem_stallM), 32'd1);
        chk("pre_rst_rd", readdataM, 32'h13579BDF);
        rst = 1'b1;
        memenM = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.data_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stallM), 32'd0);
        chk("mid_rst_rd", readdataM, 32'd0);
        next_cycle();
        rst = 1'b0;
        access(OP_LHU, 32'h402, 32'h0, 32'hA5A55A5A, 0, 0, 0, SIZE_HALF, 4'b0000, 32'h0, 32'h0000A5A5);
        idle_cycle(32'h0000A5A5);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
